pbkdf2_frame_loader: RTL and testbench

- Upstream stage of the pbkdf2 core: accepts a byte-serial job frame (iteration count, password, salt) on a valid/ready stream.
- Packs the frame into the wide, zero-padded pass/salt/salt_len/iters job word the core loads.
- Presents the job on a valid/ready output wired to the core's in_valid/in_ready.
- Malformed frames are rejected and drained; no job is produced for them.

---
 rtl/pbkdf2_pkg.sv | 25 ++
 rtl/pbkdf2_frame_loader_if.sv | 26 ++
 rtl/pbkdf2_byte_packer.sv | 33 +++
 rtl/pbkdf2_frame_loader.sv | 187 ++++++++++++++++++
 tb/tb_pbkdf2_frame_loader.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pbkdf2_pkg.sv
// Shared types and constants for the pbkdf2 front end: block/job layout and the
// frame loader state encoding.
package pbkdf2_pkg;

    localparam int PBKDF2_BLOCK_BYTES = 64;
    localparam int PBKDF2_HDR_BYTES   = 6;

    typedef logic [8*PBKDF2_BLOCK_BYTES-1:0] pbkdf2_block_t;

    typedef struct packed {
        logic [31:0]   iters;
        pbkdf2_block_t pass;
        pbkdf2_block_t salt;
        logic [5:0]    salt_len;
    } pbkdf2_job_t;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_PASS,
        ST_SALT,
        ST_HOLD,
        ST_DRAIN
    } loader_state_t;

endpackage

// File: rtl/pbkdf2_frame_loader_if.sv
// Byte-stream input and job output of the frame loader. The master modport is
// the loader itself; slave is whatever feeds bytes and consumes jobs.
interface pbkdf2_frame_loader_if;

    logic [7:0]                s_data;
    logic                      s_valid;
    logic                      s_last;
    logic                      s_ready;
    logic [31:0]               m_iters;
    pbkdf2_pkg::pbkdf2_block_t m_pass;
    pbkdf2_pkg::pbkdf2_block_t m_salt;
    logic [5:0]                m_salt_len;
    logic                      m_valid;
    logic                      m_ready;

    modport master (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_iters, m_pass, m_salt, m_salt_len, m_valid
    );

    modport slave (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_iters, m_pass, m_salt, m_salt_len, m_valid
    );

endinterface

// File: rtl/pbkdf2_byte_packer.sv
// 512-bit lane writer: byte idx lands in lane idx counting from the MSB end.
// A clear zeroes every lane and takes priority over a write in the same cycle.
module pbkdf2_byte_packer
    import pbkdf2_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr,
    input  logic          wr,
    input  logic [5:0]    idx,
    input  logic [7:0]    data,
    output pbkdf2_block_t block
);

    generate
        for (genvar gi = 0; gi < PBKDF2_BLOCK_BYTES; gi++) begin : g_lane
            logic [7:0] lane_reg;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    lane_reg <= '0;
                end else if (clr) begin
                    lane_reg <= '0;
                end else if (wr && (idx == 6'(gi))) begin
                    lane_reg <= data;
                end
            end

            assign block[8*(PBKDF2_BLOCK_BYTES-1-gi) +: 8] = lane_reg;
        end
    endgenerate

endmodule

// File: rtl/pbkdf2_frame_loader.sv
// Parses byte-serial pbkdf2 job frames into a wide job word with header checks.
// Optional macro PBKDF2_LOADER_ERRCNT_EN adds a saturating rejected-frame counter.
module pbkdf2_frame_loader
    import pbkdf2_pkg::*;
#(
    parameter int MAX_PASS_BYTES = 64,
    parameter int MAX_SALT_BYTES = 63
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    pbkdf2_frame_loader_if.master bus,
`ifdef PBKDF2_LOADER_ERRCNT_EN
    output logic [15:0]           err_cnt_o,
`endif
    output logic                  err_o
);

    localparam logic [7:0] MAX_PASS = 8'(MAX_PASS_BYTES);
    localparam logic [7:0] MAX_SALT = 8'(MAX_SALT_BYTES);
    localparam logic [5:0] HDR_LAST = 6'(PBKDF2_HDR_BYTES - 1);

    loader_state_t state_reg, state_next;
    logic [5:0]    cnt_reg, cnt_next;
    logic [31:0]   iters_reg, iters_next;
    logic [7:0]    pass_len_reg, pass_len_next;
    logic [5:0]    salt_len_reg, salt_len_next;
    logic          ready_reg, ready_next;
    logic          err_reg, err_next;
    logic          accept, pass_wr, salt_wr, clr;
    logic          hdr_bad, frame_empty, sect_end;
    logic [7:0]    cnt_plus;
    pbkdf2_block_t pass_block, salt_block;
    pbkdf2_job_t   job;

    assign accept   = bus.s_valid && ready_reg;
    assign cnt_plus = {2'b00, cnt_reg} + 8'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= ST_HDR;
            cnt_reg      <= '0;
            iters_reg    <= '0;
            pass_len_reg <= '0;
            salt_len_reg <= '0;
            ready_reg    <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            iters_reg    <= iters_next;
            pass_len_reg <= pass_len_next;
            salt_len_reg <= salt_len_next;
            ready_reg    <= ready_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        iters_next    = iters_reg;
        pass_len_next = pass_len_reg;
        salt_len_next = salt_len_reg;
        err_next      = 1'b0;
        pass_wr       = 1'b0;
        salt_wr       = 1'b0;
        hdr_bad       = 1'b0;
        frame_empty   = 1'b0;
        sect_end      = 1'b0;
        case (state_reg)
            ST_HDR: if (accept) begin
                cnt_next = cnt_reg + 6'd1;
                if (cnt_reg < 6'd4) iters_next = {iters_reg[23:0], bus.s_data};
                if (cnt_reg == 6'd4) pass_len_next = bus.s_data;
                if (cnt_reg == HDR_LAST) begin
                    // salt_len is checked straight off the bus; it is not registered yet
                    salt_len_next = bus.s_data[5:0];
                    cnt_next      = '0;
                    hdr_bad       = (iters_reg == '0) || (pass_len_reg > MAX_PASS) ||
                                    (bus.s_data > MAX_SALT);
                    frame_empty   = (pass_len_reg == '0) && (bus.s_data == '0);
                    if (hdr_bad) begin
                        if (bus.s_last) err_next = 1'b1;
                        else            state_next = ST_DRAIN;
                    end else if (frame_empty) begin
                        state_next = bus.s_last ? ST_HOLD : ST_DRAIN;
                    end else if (bus.s_last) begin
                        err_next = 1'b1;
                    end else begin
                        state_next = (pass_len_reg != '0) ? ST_PASS : ST_SALT;
                    end
                end else if (bus.s_last) begin
                    err_next = 1'b1;
                    cnt_next = '0;
                end
            end
            ST_PASS: if (accept) begin
                pass_wr  = 1'b1;
                cnt_next = cnt_reg + 6'd1;
                sect_end = (cnt_plus == pass_len_reg);
                if (sect_end) begin
                    cnt_next = '0;
                    if (salt_len_reg == '0) begin
                        state_next = bus.s_last ? ST_HOLD : ST_DRAIN;
                    end else if (bus.s_last) begin
                        err_next   = 1'b1;
                        state_next = ST_HDR;
                    end else begin
                        state_next = ST_SALT;
                    end
                end else if (bus.s_last) begin
                    err_next   = 1'b1;
                    state_next = ST_HDR;
                    cnt_next   = '0;
                end
            end
            ST_SALT: if (accept) begin
                salt_wr  = 1'b1;
                cnt_next = cnt_reg + 6'd1;
                sect_end = (cnt_plus == {2'b00, salt_len_reg});
                if (sect_end) begin
                    cnt_next   = '0;
                    state_next = bus.s_last ? ST_HOLD : ST_DRAIN;
                end else if (bus.s_last) begin
                    err_next   = 1'b1;
                    state_next = ST_HDR;
                    cnt_next   = '0;
                end
            end
            ST_HOLD: if (bus.m_ready) state_next = ST_HDR;
            ST_DRAIN: if (accept && bus.s_last) begin
                err_next   = 1'b1;
                state_next = ST_HDR;
            end
            default: state_next = ST_HDR;
        endcase
    end

    // ready is registered from the next state, so m_ready never reaches s_ready combinationally
    assign ready_next = (state_next != ST_HOLD);
    assign clr        = (state_next == ST_HDR);

    pbkdf2_byte_packer u_pass_packer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr    (clr),
        .wr     (pass_wr),
        .idx    (cnt_reg),
        .data   (bus.s_data),
        .block  (pass_block)
    );

    pbkdf2_byte_packer u_salt_packer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr    (clr),
        .wr     (salt_wr),
        .idx    (cnt_reg),
        .data   (bus.s_data),
        .block  (salt_block)
    );

    assign job = '{iters: iters_reg, pass: pass_block, salt: salt_block, salt_len: salt_len_reg};

    assign bus.s_ready    = ready_reg;
    assign bus.m_valid    = (state_reg == ST_HOLD);
    assign bus.m_iters    = job.iters;
    assign bus.m_pass     = job.pass;
    assign bus.m_salt     = job.salt;
    assign bus.m_salt_len = job.salt_len;
    assign err_o          = err_reg;

`ifdef PBKDF2_LOADER_ERRCNT_EN
    logic [15:0] err_cnt_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_reg <= '0;
        end else if (err_next && (err_cnt_reg != 16'hFFFF)) begin
            err_cnt_reg <= err_cnt_reg + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt_reg;
`endif

endmodule

// File: tb/tb_pbkdf2_frame_loader.sv
// Scoreboard bench for pbkdf2_frame_loader: stimulus pushes expected jobs/errors,
// a negedge monitor pops and compares on every job handshake and err pulse.
module tb_pbkdf2_frame_loader;
    import pbkdf2_pkg::*;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        bit            is_err;
        logic [31:0]   iters;
        pbkdf2_block_t pass;
        pbkdf2_block_t salt;
        logic [5:0]    salt_len;
    } exp_t;

    localparam pbkdf2_block_t PASS_A = {64'h70617373776f7264, 448'h0};
    localparam pbkdf2_block_t SALT_A = {32'h73616c74, 480'h0};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic err;
`ifdef PBKDF2_LOADER_ERRCNT_EN
    logic [15:0] err_cnt;
`endif
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [7:0] frame_q[$];

    pbkdf2_frame_loader_if bus();

    pbkdf2_frame_loader dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .bus       (bus),
`ifdef PBKDF2_LOADER_ERRCNT_EN
        .err_cnt_o (err_cnt),
`endif
        .err_o     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic pbkdf2_block_t pack_q(input bq_t q);
        pbkdf2_block_t b = '0;
        for (int i = 0; i < q.size(); i++) b[511-8*i -: 8] = q[i];
        return b;
    endfunction

    task automatic build(input logic [31:0] it, input logic [7:0] pl, input logic [7:0] sl,
                         input bq_t p, input bq_t s);
        frame_q.delete();
        frame_q.push_back(it[31:24]);
        frame_q.push_back(it[23:16]);
        frame_q.push_back(it[15:8]);
        frame_q.push_back(it[7:0]);
        frame_q.push_back(pl);
        frame_q.push_back(sl);
        foreach (p[i]) frame_q.push_back(p[i]);
        foreach (s[i]) frame_q.push_back(s[i]);
    endtask

    task automatic expect_job(input logic [31:0] it, input pbkdf2_block_t p,
                              input pbkdf2_block_t s, input logic [5:0] sl);
        exp_t e;
        e.is_err = 1'b0; e.iters = it; e.pass = p; e.salt = s; e.salt_len = sl;
        exp_q.push_back(e);
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1; e.iters = '0; e.pass = '0; e.salt = '0; e.salt_len = '0;
        exp_q.push_back(e);
    endtask

    // Called on a negedge; returns on the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] d, input logic last);
        int guard = 0;
        bus.s_data  = d;
        bus.s_valid = 1'b1;
        bus.s_last  = last;
        while (!bus.s_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("send_ready", 512'(bus.s_ready), 512'(1'b1));
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic run_frame(input int last_idx);
        for (int i = 0; i <= last_idx; i++) send_byte(frame_q[i], i == last_idx);
    endtask

    // Monitor: one line per observed transaction, compared against the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.m_valid && bus.m_ready) begin
                    $display("[%0t] job iters=%h salt_len=%0d", $time, bus.m_iters, bus.m_salt_len);
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_job: got iters %h, required no job", bus.m_iters);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("job_kind", 512'(mon_e.is_err), 512'(1'b0));
                        if (!mon_e.is_err) begin
                            chk("job_iters", 512'(bus.m_iters), 512'(mon_e.iters));
                            chk("job_pass", bus.m_pass, mon_e.pass);
                            chk("job_salt", bus.m_salt, mon_e.salt);
                            chk("job_salt_len", 512'(bus.m_salt_len), 512'(mon_e.salt_len));
                        end
                    end
                end
                if (err) begin
                    $display("[%0t] err pulse", $time);
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_err: got err pulse, required none");
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("err_kind", 512'(mon_e.is_err), 512'(1'b1));
                    end
                end
            end
        end
    end

    initial begin
        bq_t none, p65, s1, p64, s63;
        int  g;
        bus.s_data = '0; bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.m_ready = 1'b1;
        for (int i = 0; i < 65; i++) p65.push_back(8'h11);
        s1.push_back(8'h22);
        for (int i = 0; i < 64; i++) p64.push_back(8'(i + 1));
        for (int i = 0; i < 63; i++) s63.push_back(8'(8'h80 + i));

        // reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_s_ready", 512'(bus.s_ready), 512'(1'b0));
        chk("rst_m_valid", 512'(bus.m_valid), 512'(1'b0));
        chk("rst_err", 512'(err), 512'(1'b0));
        chk("rst_iters", 512'(bus.m_iters), 512'(32'h0));
        chk("rst_pass", bus.m_pass, 512'h0);
        chk("rst_salt", bus.m_salt, 512'h0);
        chk("rst_salt_len", 512'(bus.m_salt_len), 512'(6'd0));
`ifdef PBKDF2_LOADER_ERRCNT_EN
        chk("rst_err_cnt", 512'(err_cnt), 512'(16'd0));
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_s_ready", 512'(bus.s_ready), 512'(1'b1));

        // basic frame with latency check
        build(32'h1000, 8'd8, 8'd4, str2q("password"), str2q("salt"));
        expect_job(32'h1000, PASS_A, SALT_A, 6'd4);
        for (int i = 0; i < 17; i++) send_byte(frame_q[i], 1'b0);
        chk("pre_last_m_valid", 512'(bus.m_valid), 512'(1'b0));
        send_byte(frame_q[17], 1'b1);
        chk("latency_m_valid", 512'(bus.m_valid), 512'(1'b1));

        // backpressure: job held stable, input stalled
        @(posedge clk); #1 bus.m_ready = 1'b0;
        @(negedge clk);
        expect_job(32'h1000, PASS_A, SALT_A, 6'd4);
        run_frame(17);
        for (int i = 0; i < 20; i++) begin
            chk("hold_m_valid", 512'(bus.m_valid), 512'(1'b1));
            chk("hold_s_ready", 512'(bus.s_ready), 512'(1'b0));
            chk("hold_pass", bus.m_pass, PASS_A);
            chk("hold_iters", 512'(bus.m_iters), 512'(32'h1000));
            @(negedge clk);
        end
        @(posedge clk); #1 bus.m_ready = 1'b1;
        @(negedge clk);
        chk("hs_cycle_s_ready", 512'(bus.s_ready), 512'(1'b0));
        @(posedge clk); #1;
        chk("after_hs_s_ready", 512'(bus.s_ready), 512'(1'b1));
        chk("after_hs_m_valid", 512'(bus.m_valid), 512'(1'b0));
        @(negedge clk);

        // iters == 0 rejected, then a good frame
        build(32'h0, 8'd8, 8'd4, str2q("password"), str2q("salt"));
        expect_err();
        run_frame(17);
        chk("iters0_err", 512'(err), 512'(1'b1));
        chk("iters0_no_valid", 512'(bus.m_valid), 512'(1'b0));
        build(32'h01020304, 8'd8, 8'd4, str2q("password"), str2q("salt"));
        expect_job(32'h01020304, PASS_A, SALT_A, 6'd4);
        run_frame(17);

        // pass_len one over the limit, then both lengths at the limit
        build(32'h1, 8'd65, 8'd1, p65, s1);
        expect_err();
        run_frame(71);
        build(32'hFFFFFFFF, 8'd64, 8'd63, p64, s63);
        expect_job(32'hFFFFFFFF, pack_q(p64), pack_q(s63), 6'd63);
        run_frame(132);

        // zero-length password and salt; salt-only frame
        build(32'h5, 8'd0, 8'd0, none, none);
        expect_job(32'h5, '0, '0, 6'd0);
        run_frame(5);
        build(32'hA, 8'd0, 8'd2, none, str2q("hi"));
        expect_job(32'hA, '0, {16'h6869, 496'h0}, 6'd2);
        run_frame(7);

        // premature last on the 3rd salt byte
        build(32'h1000, 8'd8, 8'd4, str2q("password"), str2q("salt"));
        expect_err();
        run_frame(16);
        chk("premature_err", 512'(err), 512'(1'b1));

        // last missing on the final salt byte: drain until a last arrives
        build(32'h1000, 8'd8, 8'd4, str2q("password"), str2q("salt"));
        expect_err();
        for (int i = 0; i < 18; i++) send_byte(frame_q[i], 1'b0);
        chk("missing_last_no_valid", 512'(bus.m_valid), 512'(1'b0));
        chk("missing_last_no_err", 512'(err), 512'(1'b0));
        send_byte(8'hEE, 1'b0);
        send_byte(8'hEF, 1'b1);
        chk("missing_last_err", 512'(err), 512'(1'b1));

        // reset in the middle of the password
        build(32'h55, 8'd8, 8'd4, str2q("zzzzzzzz"), str2q("qqqq"));
        for (int i = 0; i < 9; i++) send_byte(frame_q[i], 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_s_ready", 512'(bus.s_ready), 512'(1'b0));
        chk("midrst_pass", bus.m_pass, 512'h0);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef PBKDF2_LOADER_ERRCNT_EN
        chk("midrst_err_cnt", 512'(err_cnt), 512'(16'd0));
`endif
        @(negedge clk);
        build(32'h77, 8'd2, 8'd1, str2q("ab"), str2q("x"));
        expect_job(32'h77, {16'h6162, 496'h0}, {8'h78, 504'h0}, 6'd1);
        run_frame(8);

        // last inside the header
        build(32'h1, 8'd1, 8'd1, str2q("a"), str2q("b"));
        expect_err();
        run_frame(2);
        chk("hdr_last_err", 512'(err), 512'(1'b1));
`ifdef PBKDF2_LOADER_ERRCNT_EN
        chk("err_cnt_inc", 512'(err_cnt), 512'(16'd1));
`endif

        g = 0;
        while (exp_q.size() != 0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("scoreboard_drained", 512'(exp_q.size()), 512'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
